fetch_stage: RTL
================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter ADDR_W, 10: instruction-memory address width.
REQ-002 Parameter RESET_PC, 0: PC value loaded on reset.
REQ-003 clk  input  1  single system clock; all state updates on posedge clk.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 freeze  input  1  stall request from hazard logic; fetch holds.
REQ-006 update_pc  input  1  branch/jump redirect; flushes fetch.
REQ-007 new_pc  input  ADDR_W  redirect target, sampled when update_pc=1.
REQ-008 imem_addr  output  ADDR_W  combinational copy of internal PC to instruction memory.
REQ-009 imem_data  input  16  instruction word at imem_addr, same-cycle (asynchronous read).
REQ-010 instr_out  output  16  registered instruction to the 16-bit decode pipeline register.
REQ-011 pc_out  output  ADDR_W  registered address of the word in instr_out.
REQ-012 instr_valid  output  1  instr_out holds a real fetched word, not a bubble.
REQ-013 halted  output  1  fetch stopped by a HLT instruction.
REQ-014 fetch_count  output  16  saturating count of valid words issued.

Function
REQ-015 BUBBLE shall equal {`NPHLT, `NOP, 9'b0}; opcode field = instr[15:9]; a word is HALT when instr[15:9] == {`HLT, `NOP}-encoded halt opcode from the shared definitions file.
REQ-016 FSM states: RUN, HALTED; only RUN fetches.
REQ-017 RUN, freeze=0, update_pc=0: instr_out<=imem_data, pc_out<=pc, instr_valid<=1, pc<=pc+1, fetch_count increments.
REQ-018 Latency: word at address A appears on instr_out exactly one cycle after pc==A.
REQ-019 RUN, freeze=1, update_pc=0: pc, instr_out, pc_out, instr_valid, fetch_count all hold.
REQ-020 update_pc=1 (any state, any freeze): pc<=new_pc, instr_out<=BUBBLE, instr_valid<=0, state<=RUN, halted<=0; redirect overrides freeze and halt.
REQ-021 PC arithmetic modulo 2^ADDR_W: pc=2^ADDR_W-1 increments to 0 without flag or stall.
REQ-022 RUN, fetched word is HALT (freeze=0, update_pc=0): HALT word issued normally (instr_valid=1), pc does not increment, state<=HALTED, halted<=1 same edge.
REQ-023 HALTED, update_pc=0: instr_out<=BUBBLE, instr_valid<=0, pc holds, fetch_count holds, freeze ignored.
REQ-024 fetch_count saturates at 16'hFFFF; never wraps.
REQ-025 imem_addr shall always equal pc, including during freeze and HALTED.

Reset
REQ-026 rst_n=0 asynchronously forces: pc=RESET_PC, state=RUN, instr_out=BUBBLE, pc_out=0, instr_valid=0, halted=0, fetch_count=0.
REQ-027 Reset asserted mid-stall, mid-redirect or in HALTED overrides all inputs; first fetch of RESET_PC occurs on first posedge with rst_n=1 and freeze=0.

Verification
REQ-028 Reset release, memory 0..3 = 16'h1201,16'h1402,16'h1603,16'h1804, freeze=0 -> instr_out sequence 1201,1402,1603,1804 on cycles 1..4, pc_out 0..3, fetch_count=4.
REQ-029 freeze=1 for 3 cycles after instr at pc 2 -> instr_out stays at word 2, imem_addr stays 3, fetch resumes with word 3 after freeze drops.
REQ-030 update_pc=1, freeze=1, new_pc=10'h200 simultaneous -> next cycle instr_out=BUBBLE, instr_valid=0, imem_addr=10'h200; following cycle instr_out=mem[10'h200].
REQ-031 HALT at address 5 -> HALT word issued with pc_out=5, halted=1, then BUBBLE every cycle for 10 cycles, imem_addr=5; update_pc to 0 clears halted, fetch restarts at 0.
REQ-032 pc forced by redirect to 10'h3FF -> fetches 3FF then 000, no glitch on instr_valid.
REQ-033 rst_n pulsed low mid-cycle while HALTED -> outputs reset immediately without clock edge, halted=0, fetch_count=0.

Source files
------------

// File: rtl/fetch_stage.sv
// ----------------------------------------------------------------------------
// fetch_stage
//
// Instruction fetch stage for the 16-bit pipeline.
// - A program counter drives the instruction memory address.
// - The word returned in the same cycle is registered into the decode pipeline
//   register, together with the address it came from.
//
// Ports
//   clk          in   system clock, all state changes on the rising edge
//   rst_n        in   asynchronous active-low reset
//   freeze       in   stall from hazard logic; the fetch stage holds
//   update_pc    in   branch/jump redirect; loads new_pc and flushes fetch
//   new_pc       in   redirect target, sampled while update_pc=1
//   imem_addr    out  current PC (combinational) to the instruction memory
//   imem_data    in   instruction word at imem_addr (asynchronous read)
//   instr_out    out  registered instruction for the decode stage
//   pc_out       out  registered address of the word held in instr_out
//   instr_valid  out  instr_out holds a fetched word rather than a bubble
//   halted       out  fetch stopped by a HLT instruction (reflects FSM state)
//   fetch_count  out  saturating count of valid words issued
//
// Flow control
//   There is no ready input. freeze=1 means the consumer cannot accept a new
//   word, so instr_out/pc_out/instr_valid are held until freeze drops.
//   update_pc takes priority over freeze and over the halted state. A word
//   is issued on every edge where the stage is running, not frozen and not
//   redirected.
// ----------------------------------------------------------------------------
module fetch_stage #(
    parameter int ADDR_W   = 10,
    parameter int RESET_PC = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              freeze,
    input  logic              update_pc,
    input  logic [ADDR_W-1:0] new_pc,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [15:0]       imem_data,
    output logic [15:0]       instr_out,
    output logic [ADDR_W-1:0] pc_out,
    output logic              instr_valid,
    output logic              halted,
    output logic [15:0]       fetch_count
);

    // ISA opcode pieces, matching the shared instruction-set definitions.
    // The opcode field is instr[15:9] = {class[4:0], sub[1:0]}.
    localparam logic [4:0] OP_CLASS_NPHLT = 5'b11110;
    localparam logic [4:0] OP_CLASS_HLT   = 5'b11111;
    localparam logic [1:0] OP_SUB_NOP     = 2'b00;

    localparam logic [15:0] BUBBLE  = {OP_CLASS_NPHLT, OP_SUB_NOP, 9'b0};
    localparam logic [6:0]  HALT_OP = {OP_CLASS_HLT, OP_SUB_NOP};

    localparam logic [ADDR_W-1:0] PC_RST = ADDR_W'(RESET_PC);

    // FSM encoding
    localparam logic [0:0] ST_RUN    = 1'b0;
    localparam logic [0:0] ST_HALTED = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [15:0]       instr_q, instr_d;
    logic [ADDR_W-1:0] pc_out_q, pc_out_d;
    logic              valid_q, valid_d;
    logic [15:0]       count_q, count_d;

    logic              is_halt_word;
    logic [15:0]       count_inc;

    assign is_halt_word = (imem_data[15:9] == HALT_OP);

    // Saturating increment: the counter sticks at all-ones.
    assign count_inc = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        pc_out_d = pc_out_q;
        valid_d  = valid_q;
        count_d  = count_q;

        if (update_pc) begin
            // Redirect wins over freeze and over the halted state.
            // pc_out is left as-is because the bubble carries no address.
            pc_d    = new_pc;
            instr_d = BUBBLE;
            valid_d = 1'b0;
            state_d = ST_RUN;
        end else if (state_q == ST_HALTED) begin
            // Emit bubbles forever; freeze has no effect here.
            instr_d = BUBBLE;
            valid_d = 1'b0;
        end else if (!freeze) begin
            instr_d  = imem_data;
            pc_out_d = pc_q;
            valid_d  = 1'b1;
            count_d  = count_inc;
            if (is_halt_word) begin
                // The HLT word itself is issued, but the PC parks on it.
                state_d = ST_HALTED;
            end else begin
                // Wraps modulo 2^ADDR_W by width truncation.
                pc_d = pc_q + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_RUN;
            pc_q     <= PC_RST;
            instr_q  <= BUBBLE;
            pc_out_q <= '0;
            valid_q  <= 1'b0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            pc_out_q <= pc_out_d;
            valid_q  <= valid_d;
            count_q  <= count_d;
        end
    end

    assign imem_addr   = pc_q;
    assign instr_out   = instr_q;
    assign pc_out      = pc_out_q;
    assign instr_valid = valid_q;
    assign halted      = (state_q == ST_HALTED);
    assign fetch_count = count_q;

endmodule
